// File: rtl/layer_mem_write_ctr.sv
// Write-address generator and write-enable sequencer for a layer's output RAM.
// It waits START_DELAY enabled cycles, then writes one word per valid result across CHANNELS x DEPTH addresses.
module layer_mem_write_ctr #(
    parameter int DEPTH       = 16,
    parameter int CHANNELS    = 1,
    parameter int START_DELAY = 1,
    parameter int ADDR_W      = 4,
    parameter int CH_W        = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              start,
    input  logic              in_valid,
    output logic [ADDR_W-1:0] addr,
    output logic [CH_W-1:0]   ch,
    output logic              we,
    output logic              busy,
    output logic              done
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int DLY_W = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(CHANNELS - 1);
    localparam logic [DLY_W-1:0] LAST_DLY = DLY_W'((START_DELAY > 0) ? START_DELAY - 1 : 0);

    if (DEPTH < 1 || CHANNELS < 1) begin : g_bad_geometry
        $error("layer_mem_write_ctr: DEPTH and CHANNELS must both be >= 1");
    end
    if (DEPTH * CHANNELS > 2**ADDR_W) begin : g_bad_addr_w
        $error("layer_mem_write_ctr: DEPTH*CHANNELS does not fit in ADDR_W bits");
    end
    if (CH_W < ((CHANNELS > 1) ? $clog2(CHANNELS) : 1)) begin : g_bad_ch_w
        $error("layer_mem_write_ctr: CH_W too narrow for CHANNELS");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_DELAY,
        S_WRITE,
        S_DONE
    } state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [CH_W-1:0]   ch_q;
    logic [IDX_W-1:0]  idx_q;
    logic [DLY_W-1:0]  dly_q;
    logic              busy_q;
    logic              done_q;
    logic              last_word;

    assign last_word = (idx_q == LAST_IDX) && (ch_q == LAST_CH);

    // NOTE: we is a continuous function of state and inputs, so a start pulse suppresses the write in its own cycle.
    assign we = (state_q == S_WRITE) && enable && in_valid && !start;

    // NOTE: all state uses non-blocking assignments so every register sees pre-edge values of the others.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            ch_q    <= '0;
            idx_q   <= '0;
            dly_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (start) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            ch_q    <= '0;
            idx_q   <= '0;
            dly_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (enable) begin
                        busy_q <= 1'b1;
                        dly_q  <= '0;
                        if (START_DELAY > 0) state_q <= S_DELAY;
                        else                 state_q <= S_WRITE;
                    end
                end
                S_DELAY: begin
                    if (enable) begin
                        if (dly_q == LAST_DLY) state_q <= S_WRITE;
                        else                   dly_q   <= dly_q + DLY_W'(1);
                    end
                end
                S_WRITE: begin
                    if (we) begin
                        if (last_word) begin
                            // The final address and channel are held, not wrapped.
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            addr_q <= addr_q + ADDR_W'(1);
                            if (idx_q == LAST_IDX) begin
                                idx_q <= '0;
                                ch_q  <= ch_q + CH_W'(1);
                            end else begin
                                idx_q <= idx_q + IDX_W'(1);
                            end
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_DONE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign addr = addr_q;
    assign ch   = ch_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
